// File: rtl/j_cp_latch_bank_pkg.sv
// j_pkg: definitions shared by the Jerry pending-latch bank.
//   J_CP_MAXCH  - the largest supported channel count.
//   clog2_min1  - index width for a channel count. It returns at least 1, so a
//                 one-channel bank still has a 1-bit irq_id port.
package j_pkg;

  localparam int J_CP_MAXCH = 16;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/j_cp_latch_bank_if.sv
// j_cp_latch_bank_if: the bus between the pending-latch bank and the logic
// around it. sys_clk and reset_n are not part of this bus; they stay plain
// ports on the bank.
//   cen      - sample strobe. Hardware set/clear are looked at only while it is 1.
//   set      - per-channel set request.
//   clear    - per-channel hardware clear.
//   wr_clr   - CPU write strobe.
//   wr_data  - write-1-to-clear data, used when wr_clr=1.
//   mask     - per-channel enable for irq/irq_id.
//   q        - raw pending latches.
//   ovf      - sticky overflow flags.
//   irq      - registered OR of (q & mask).
//   irq_id   - registered index of the lowest pending enabled channel.
// Signalling: there is no valid/ready pair. Every input is a level that is
// sampled on each rising edge of sys_clk. cen and wr_clr act as per-cycle
// qualifiers, and nothing is ever back-pressured.
interface j_cp_latch_bank_if
  import j_pkg::*;
#(
  parameter int N   = 5,
  parameter int IDW = clog2_min1(N)
);
  logic           cen;
  logic [N-1:0]   set;
  logic [N-1:0]   clear;
  logic           wr_clr;
  logic [N-1:0]   wr_data;
  logic [N-1:0]   mask;
  logic [N-1:0]   q;
  logic [N-1:0]   ovf;
  logic           irq;
  logic [IDW-1:0] irq_id;

  modport master (
    output cen, set, clear, wr_clr, wr_data, mask,
    input  q, ovf, irq, irq_id
  );

  modport slave (
    input  cen, set, clear, wr_clr, wr_data, mask,
    output q, ovf, irq, irq_id
  );
endinterface

// File: rtl/j_cp_latch_bank_prienc.sv
// j_cp_prienc: combinational priority encoder. The lowest set index wins.
//   req   in  N    request vector
//   valid out 1    any request set
//   idx   out IDW  lowest set index, or 0 when nothing is set
module j_cp_prienc
  import j_pkg::*;
#(
  parameter int N   = 5,
  parameter int IDW = clog2_min1(N)
) (
  input  logic [N-1:0]   req,
  output logic           valid,
  output logic [IDW-1:0] idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan from the top down, so the last hit kept is the lowest index.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDW'(i);
    end
  end

endmodule

// File: rtl/j_cp_latch_bank.sv
// j_cp_latch_bank: a bank of N set/clear pending latches. Jerry uses them for
// interrupt-pending and CPU-semaphore flags.
//   sys_clk  in   system clock. All state changes on its rising edge.
//   reset_n  in   synchronous active-low reset.
//   bus      slave modport of j_cp_latch_bank_if (cen, set, clear, wr_clr,
//            wr_data, mask in; q, ovf, irq, irq_id out).
// Each channel sets on a level or on a rising edge (EDGE_MASK). SET_WINS picks
// the winner when a set and a clear arrive together. The CPU clear
// (wr_clr & wr_data) is applied on every cycle, whatever cen is. irq and
// irq_id are registered from the current q & mask, so they trail q by one cycle.
module j_cp_latch_bank
  import j_pkg::*;
#(
  parameter int           N         = 5,   // 1..J_CP_MAXCH
  parameter logic [N-1:0] EDGE_MASK = '0,
  parameter bit           SET_WINS  = 1'b0,
  parameter int           IDW       = clog2_min1(N)
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  j_cp_latch_bank_if.slave   bus
);

  logic [N-1:0]   q_q,        q_d;
  logic [N-1:0]   ovf_q,      ovf_d;
  // set_prev holds the previous cen-qualified sample of set. Reset loads all
  // ones, so a set that is held high through reset is not taken as an edge.
  logic [N-1:0]   set_prev_q, set_prev_d;
  logic           irq_q,      irq_d;
  logic [IDW-1:0] irq_id_q,   irq_id_d;

  logic [N-1:0]   s_eff;
  logic [N-1:0]   c_eff;

  for (genvar i = 0; i < N; i++) begin : g_ch
    // The edge is found across cen samples, not across clock cycles.
    assign s_eff[i] = bus.cen & (EDGE_MASK[i] ? (bus.set[i] & ~set_prev_q[i])
                                              : bus.set[i]);
    assign c_eff[i] = (bus.cen & bus.clear[i]) | (bus.wr_clr & bus.wr_data[i]);

    if (SET_WINS) begin : g_set_wins
      assign q_d[i] = s_eff[i] | (~c_eff[i] & q_q[i]);
    end else begin : g_clr_wins
      assign q_d[i] = ~c_eff[i] & (q_q[i] | s_eff[i]);
    end

    // The clear always wins for ovf. Overflow is judged against the q value
    // before this update, so a set and a clear together never raise ovf.
    assign ovf_d[i] = ~c_eff[i] & (ovf_q[i] | (s_eff[i] & q_q[i]));
  end

  assign set_prev_d = bus.cen ? bus.set : set_prev_q;

  j_cp_prienc #(
    .N   (N),
    .IDW (IDW)
  ) u_prienc (
    .req   (q_q & bus.mask),
    .valid (irq_d),
    .idx   (irq_id_d)
  );

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      q_q        <= '0;
      ovf_q      <= '0;
      set_prev_q <= '1;
      irq_q      <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      set_prev_q <= set_prev_d;
      irq_q      <= irq_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign bus.q      = q_q;
  assign bus.ovf    = ovf_q;
  assign bus.irq    = irq_q;
  assign bus.irq_id = irq_id_q;

endmodule

// File: tb/tb_j_cp_latch_bank.sv
// Bench for j_cp_latch_bank. Three N=5 instances receive the same stimulus:
//   a: EDGE_MASK=5'h1F, SET_WINS=0
//   b: EDGE_MASK=5'h00, SET_WINS=0
//   c: EDGE_MASK=5'h0A, SET_WINS=1
// A per-channel reference model, written from the set/clear rules, predicts
// every output of all three instances.
module tb_j_cp_latch_bank;

  localparam int N   = 5;
  localparam int IDW = 3;
  localparam int ND  = 3;
  localparam logic [N-1:0] EM [ND] = '{5'h1F, 5'h00, 5'h0A};
  localparam bit           SW [ND] = '{1'b0, 1'b0, 1'b1};

  // ---------------- clock / reset ----------------
  logic sys_clk = 1'b0;
  logic reset_n;
  always #5 sys_clk = ~sys_clk;

  // ---------------- stimulus ----------------
  logic         cen;
  logic [N-1:0] set, clear, wr_data, mask;
  logic         wr_clr;

  j_cp_latch_bank_if #(.N(N), .IDW(IDW)) if_a ();
  j_cp_latch_bank_if #(.N(N), .IDW(IDW)) if_b ();
  j_cp_latch_bank_if #(.N(N), .IDW(IDW)) if_c ();

  assign if_a.cen = cen;  assign if_a.set = set;  assign if_a.clear = clear;
  assign if_a.wr_clr = wr_clr;  assign if_a.wr_data = wr_data;  assign if_a.mask = mask;
  assign if_b.cen = cen;  assign if_b.set = set;  assign if_b.clear = clear;
  assign if_b.wr_clr = wr_clr;  assign if_b.wr_data = wr_data;  assign if_b.mask = mask;
  assign if_c.cen = cen;  assign if_c.set = set;  assign if_c.clear = clear;
  assign if_c.wr_clr = wr_clr;  assign if_c.wr_data = wr_data;  assign if_c.mask = mask;

  j_cp_latch_bank #(.N(N), .EDGE_MASK(5'h1F), .SET_WINS(1'b0), .IDW(IDW)) dut_a (
    .sys_clk (sys_clk), .reset_n (reset_n), .bus (if_a));
  j_cp_latch_bank #(.N(N), .EDGE_MASK(5'h00), .SET_WINS(1'b0), .IDW(IDW)) dut_b (
    .sys_clk (sys_clk), .reset_n (reset_n), .bus (if_b));
  j_cp_latch_bank #(.N(N), .EDGE_MASK(5'h0A), .SET_WINS(1'b1), .IDW(IDW)) dut_c (
    .sys_clk (sys_clk), .reset_n (reset_n), .bus (if_c));

  logic [N-1:0]   dq [ND];
  logic [N-1:0]   dovf [ND];
  logic           dirq [ND];
  logic [IDW-1:0] did [ND];
  assign dq[0] = if_a.q;  assign dovf[0] = if_a.ovf;  assign dirq[0] = if_a.irq;  assign did[0] = if_a.irq_id;
  assign dq[1] = if_b.q;  assign dovf[1] = if_b.ovf;  assign dirq[1] = if_b.irq;  assign did[1] = if_b.irq_id;
  assign dq[2] = if_c.q;  assign dovf[2] = if_c.ovf;  assign dirq[2] = if_c.irq;  assign did[2] = if_c.irq_id;

  // ---------------- reference model ----------------
  logic [N-1:0] mq [ND];
  logic [N-1:0] movf [ND];
  logic [N-1:0] mprev [ND];
  logic         mirq [ND];
  int           mid [ND];

  // Advance the model by one clock edge, using the inputs as they are now.
  task automatic model_step();
    for (int k = 0; k < ND; k++) begin
      if (!reset_n) begin
        mq[k] = '0; movf[k] = '0; mprev[k] = '1; mirq[k] = 1'b0; mid[k] = 0;
      end else begin
        logic [N-1:0] nq, novf;
        // irq/id come from the pending & enabled set as it stands before the edge
        mirq[k] = 1'b0;
        mid[k]  = 0;
        for (int i = 0; i < N; i++) begin
          if (mq[k][i] && mask[i] && !mirq[k]) begin
            mirq[k] = 1'b1;
            mid[k]  = i;
          end
        end
        for (int i = 0; i < N; i++) begin
          bit s, c;
          if (EM[k][i]) s = cen && set[i] && !mprev[k][i];
          else          s = cen && set[i];
          c = (cen && clear[i]) || (wr_clr && wr_data[i]);
          if (c)                  novf[i] = 1'b0;
          else if (s && mq[k][i]) novf[i] = 1'b1;
          else                    novf[i] = movf[k][i];
          if (SW[k]) nq[i] = s ? 1'b1 : (c ? 1'b0 : mq[k][i]);
          else       nq[i] = c ? 1'b0 : (mq[k][i] || s);
        end
        mq[k]   = nq;
        movf[k] = novf;
        if (cen) mprev[k] = set;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < ND; k++) begin
      chk($sformatf("%s_q%0d", tag, k),   32'(dq[k]),   32'(mq[k]));
      chk($sformatf("%s_ovf%0d", tag, k), 32'(dovf[k]), 32'(movf[k]));
      chk($sformatf("%s_irq%0d", tag, k), 32'(dirq[k]), 32'(mirq[k]));
      if (mirq[k]) chk($sformatf("%s_id%0d", tag, k), 32'(did[k]), 32'(mid[k]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick(input string tag);
    model_step();
    @(posedge sys_clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle_inputs();
    cen = 1'b0; set = '0; clear = '0; wr_clr = 1'b0; wr_data = '0; mask = '1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    tick("rst");
    reset_n = 1'b1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_inputs();
    reset_n = 1'b0;
    #2;

    // 1: edge-mode set held through reset must not fire
    set = 5'h1F;
    tick("t1_rst");
    tick("t1_rst");
    chk("t1_rst_q", 32'(if_a.q), 32'h0);
    chk("t1_rst_irq", 32'(if_a.irq), 32'h0);
    reset_n = 1'b1; cen = 1'b1;
    tick("t1_held");
    chk("t1_held_q", 32'(if_a.q), 32'h0);
    set = 5'h00;
    tick("t1_low");
    set = 5'h1F;
    tick("t1_rise");
    chk("t1_rise_q", 32'(if_a.q), 32'h1F);
    chk("t1_rise_irq", 32'(if_a.irq), 32'h0);
    set = 5'h00;
    tick("t1_irq");
    chk("t1_irq", 32'(if_a.irq), 32'h1);
    chk("t1_id", 32'(if_a.irq_id), 32'h0);

    // 2: simultaneous set and clear on level channel 2
    do_reset();
    cen = 1'b1; set = 5'h04; clear = 5'h04;
    tick("t2");
    chk("t2_clrwins_q2", 32'(if_b.q[2]), 32'h0);
    chk("t2_setwins_q2", 32'(if_c.q[2]), 32'h1);

    // 3: masked id, then CPU clear with cen=0
    do_reset();
    cen = 1'b1; set = 5'h14;
    tick("t3_set");
    cen = 1'b0; set = 5'h00; mask = 5'h10;
    tick("t3_mask");
    chk("t3_irq", 32'(if_b.irq), 32'h1);
    chk("t3_id", 32'(if_b.irq_id), 32'h4);
    wr_clr = 1'b1; wr_data = 5'h10;
    tick("t3_wr");
    chk("t3_wr_q", 32'(if_b.q), 32'h04);
    wr_clr = 1'b0; wr_data = 5'h00;
    tick("t3_after");
    chk("t3_after_irq", 32'(if_b.irq), 32'h0);
    mask = 5'h1F;

    // 4: level set held on a pending channel gives sticky overflow
    do_reset();
    cen = 1'b1; set = 5'h02;
    tick("t4_a");
    chk("t4_ovf_early", 32'(if_b.ovf), 32'h0);
    tick("t4_b");
    tick("t4_c");
    chk("t4_ovf", 32'(if_b.ovf), 32'h02);
    set = 5'h00;
    tick("t4_sticky");
    chk("t4_ovf_sticky", 32'(if_b.ovf), 32'h02);
    wr_clr = 1'b1; wr_data = 5'h02;
    tick("t4_wclr");
    chk("t4_wclr_q", 32'(if_b.q), 32'h0);
    chk("t4_wclr_ovf", 32'(if_b.ovf), 32'h0);
    wr_clr = 1'b0; wr_data = 5'h00;

    // 5: edge detection across sparse cen samples
    do_reset();
    cen = 1'b1; set = 5'h00;
    tick("t5_prime");
    for (int k = 0; k < 8; k++) begin
      cen = (k % 4 == 0);
      set = (k == 2) ? 5'h01 : 5'h00;
      tick("t5_miss");
    end
    chk("t5_miss_q0", 32'(if_a.q[0]), 32'h0);
    cen = 1'b1; set = 5'h01;
    tick("t5_hit");
    chk("t5_hit_q0", 32'(if_a.q[0]), 32'h1);
    cen = 1'b0; set = 5'h00;

    // 6: reset in mid-operation beats every other input
    do_reset();
    cen = 1'b1; set = 5'h1F;
    tick("t6_fill");
    set = 5'h03;
    tick("t6_ovf");
    chk("t6_pre_q", 32'(if_b.q), 32'h1F);
    chk("t6_pre_ovf", 32'(if_b.ovf), 32'h03);
    chk("t6_pre_irq", 32'(if_b.irq), 32'h1);
    reset_n = 1'b0; set = 5'h1F; clear = 5'h00; wr_clr = 1'b1; wr_data = 5'h0F;
    tick("t6_rst");
    chk("t6_q", 32'(if_b.q), 32'h0);
    chk("t6_ovf", 32'(if_b.ovf), 32'h0);
    chk("t6_irq", 32'(if_b.irq), 32'h0);
    chk("t6_id", 32'(if_b.irq_id), 32'h0);
    reset_n = 1'b1;
    idle_inputs();

    // random phase
    for (int n = 0; n < 400; n++) begin
      reset_n = ($urandom_range(0, 63) != 0);
      cen     = ($urandom_range(0, 3) != 0);
      set     = N'($urandom_range(0, 31));
      clear   = N'($urandom_range(0, 31)) & N'($urandom_range(0, 31)) & N'($urandom_range(0, 31));
      wr_clr  = ($urandom_range(0, 7) == 0);
      wr_data = N'($urandom_range(0, 31));
      mask    = N'($urandom_range(0, 31));
      tick("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
